// File: rtl/cycle_sequencer.sv
// cycle_sequencer: control-step counter, IR and PSW holder feeding the instruction decoder
module cycle_sequencer #(
  parameter int MAX_CNT    = 4,
  parameter int WAIT_LIMIT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        MemRdy,
  input  logic        MemReq,
  input  logic [15:0] MemData,
  input  logic        Buff_PC,
  input  logic        Buff_PSW,
  input  logic        Done,
  input  logic [2:0]  ALU_NZC,
  output logic [2:0]  Cnt,
  output logic [7:0]  InsM,
  output logic [1:0]  InsL,
  output logic [15:0] IR,
  output logic [1:0]  PSW_NZC,
  output logic        PSW_N,
  output logic        DecRst,
  output logic        Halted,
  output logic        BusErr,
  output logic [15:0] InsCount
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_nx;
  logic [2:0] cnt_nx, psw, psw_nx;
  logic [15:0] ir_nx, ins_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic bus_nx, stall, retire;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state    <= IDLE;
      Cnt      <= '0;
      IR       <= '0;
      psw      <= '0;
      InsCount <= '0;
      wait_cnt <= '0;
      BusErr   <= 1'b0;
    end else begin
      state    <= state_nx;
      Cnt      <= cnt_nx;
      IR       <= ir_nx;
      psw      <= psw_nx;
      InsCount <= ins_nx;
      wait_cnt <= wait_nx;
      BusErr   <= bus_nx;
    end
  always_comb begin
    stall    = (Cnt == 3'd0 || MemReq) && !MemRdy;
    retire   = Done || Buff_PC || Cnt == 3'(MAX_CNT);
    state_nx = state;
    cnt_nx   = Cnt;
    ir_nx    = IR;
    psw_nx   = psw;
    ins_nx   = InsCount;
    wait_nx  = wait_cnt;
    bus_nx   = BusErr;
    case (state)
      IDLE: begin
        cnt_nx   = '0;
        state_nx = Start ? RUN : IDLE;
      end
      RUN:
        if (stall) begin
          // timeout on the WAIT_LIMIT-th consecutive stalled cycle
          bus_nx   = BusErr || wait_cnt == 8'(WAIT_LIMIT - 1);
          state_nx = wait_cnt == 8'(WAIT_LIMIT - 1) ? HALT : RUN;
          cnt_nx   = wait_cnt == 8'(WAIT_LIMIT - 1) ? 3'd0 : Cnt;
          wait_nx  = wait_cnt + 8'd1;
        end else begin
          wait_nx  = '0;
          cnt_nx   = retire ? 3'd0 : Cnt + 3'd1;
          ins_nx   = retire ? InsCount + 16'd1 : InsCount;
          state_nx = Done ? HALT : RUN;
          ir_nx    = Cnt == 3'd0 ? MemData : IR;
          psw_nx   = Buff_PSW ? ALU_NZC : psw;
        end
      default: cnt_nx = '0;
    endcase
  end
  assign InsM    = IR[15:8];
  assign InsL    = IR[1:0];
  assign PSW_NZC = psw[1:0];
  assign PSW_N   = psw[2];
  assign DecRst  = state != RUN;
  assign Halted  = state == HALT;
endmodule
